// File: rtl/trig_phase_cal_ctrl_if.sv
// Bus bundle between the phase-calibration sequencer and its host:
// scan control, coax inputs, lock results and the last channel's histogram.
interface trig_phase_cal_ctrl_if;
    logic        start;
    logic [15:0] coax_in;
    logic [7:0]  expected_hits;
    logic        pulse_gate;
    logic [1:0]  phase;
    logic [3:0]  chan_sel;
    logic        busy;
    logic        done;
    logic [15:0] lock;
    logic [31:0] phase_sel;
    logic [7:0]  hist0;
    logic [7:0]  hist1;
    logic [7:0]  hist2;
    logic [7:0]  hist3;

    modport master (
        output start, coax_in, expected_hits,
        input  pulse_gate, phase, chan_sel, busy, done, lock, phase_sel,
        input  hist0, hist1, hist2, hist3
    );

    modport slave (
        input  start, coax_in, expected_hits,
        output pulse_gate, phase, chan_sel, busy, done, lock, phase_sel,
        output hist0, hist1, hist2, hist3
    );
endinterface

// File: rtl/trig_phase_cal_ctrl.sv
// Trigger phase calibration sequencer: scans each coax channel, histograms its
// hits into four clk_adc phase bins and records a per-channel phase lock.
module trig_phase_cal_ctrl #(
    parameter int NCHAN      = 16,
    parameter int WINDOW_LEN = 250,
    parameter int SETTLE_LEN = 8
) (
    input  logic                  clk_adc,
    input  logic                  rst,
    trig_phase_cal_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_MEASURE,
        ST_SETTLE,
        ST_EVAL,
        ST_NEXT,
        ST_DONE
    } state_t;

    localparam logic [15:0] LP_WIN_LAST    = 16'(WINDOW_LEN - 1);
    localparam logic [15:0] LP_SETTLE_LAST = 16'(SETTLE_LEN - 1);
    localparam logic [3:0]  LP_CHAN_LAST   = 4'(NCHAN - 1);

    state_t      r_state;
    state_t      w_state_next;

    logic [1:0]  r_phase;
    logic [3:0]  r_chan_sel;
    logic [15:0] r_timer;
    logic [31:0] r_bins;
    logic [31:0] w_bins_next;
    logic [31:0] r_hist;
    logic [15:0] r_lock;
    logic [15:0] w_lock_next;
    logic [31:0] r_phase_sel;
    logic [31:0] w_phase_sel_next;

    logic        w_counting;
    logic        w_hit;
    logic        w_eval;
    logic        w_win_last;
    logic        w_settle_last;
    logic        w_chan_last;
    logic [3:0]  w_nonzero;
    logic        w_single;
    logic [1:0]  w_win_idx;
    logic [7:0]  w_win_cnt;
    logic        w_lock_ok;

    assign w_counting    = (r_state == ST_MEASURE) || (r_state == ST_SETTLE);
    assign w_hit         = w_counting && bus.coax_in[r_chan_sel];
    assign w_eval        = (r_state == ST_EVAL);
    assign w_win_last    = (r_timer == LP_WIN_LAST);
    assign w_settle_last = (r_timer == LP_SETTLE_LAST);
    assign w_chan_last   = (r_chan_sel == LP_CHAN_LAST);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_adc or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_state_next = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (w_win_last) begin
                    w_state_next = (SETTLE_LEN == 0) ? ST_EVAL : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_settle_last) begin
                    w_state_next = ST_EVAL;
                end
            end
            ST_EVAL: begin
                w_state_next = ST_NEXT;
            end
            ST_NEXT: begin
                w_state_next = w_chan_last ? ST_DONE : ST_CLEAR;
            end
            ST_DONE: begin
                // A start coinciding with DONE is dropped, not queued.
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Phase bins: saturating 8-bit counters, one per clk_adc phase
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bin
            logic [7:0] w_cur;
            assign w_cur          = r_bins[gi*8 +: 8];
            assign w_nonzero[gi]  = (w_cur != 8'd0);
            assign w_bins_next[gi*8 +: 8] =
                (r_state == ST_CLEAR)                                   ? 8'd0 :
                (w_hit && (r_phase == 2'(gi)) && (w_cur != 8'hFF))      ? w_cur + 8'd1 :
                                                                          w_cur;
        end
    endgenerate

    always_comb begin
        w_win_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (w_nonzero[k]) begin
                w_win_idx = 2'(k);
            end
        end
    end

    // All-zero bins never lock, even with a zero hit threshold.
    assign w_single  = $onehot(w_nonzero);
    assign w_win_cnt = r_bins[{w_win_idx, 3'b000} +: 8];
    assign w_lock_ok = w_single && (w_win_cnt >= bus.expected_hits);

    // ------------------------------------------------------------------
    // Per-channel results; channels beyond NCHAN stay at zero
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_chan
            if (gi < NCHAN) begin : g_used
                logic w_sel;
                assign w_sel = w_eval && (r_chan_sel == 4'(gi));
                assign w_lock_next[gi] = w_sel ? w_lock_ok : r_lock[gi];
                assign w_phase_sel_next[gi*2 +: 2] =
                    (w_sel && w_lock_ok) ? w_win_idx : r_phase_sel[gi*2 +: 2];
            end else begin : g_unused
                assign w_lock_next[gi]             = 1'b0;
                assign w_phase_sel_next[gi*2 +: 2] = 2'b00;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_adc or posedge rst) begin
        if (rst) begin
            r_phase     <= 2'd0;
            r_chan_sel  <= 4'd0;
            r_timer     <= 16'd0;
            r_bins      <= 32'd0;
            r_hist      <= 32'd0;
            r_lock      <= 16'd0;
            r_phase_sel <= 32'd0;
        end else begin
            r_phase     <= r_phase + 2'd1;
            r_bins      <= w_bins_next;
            r_lock      <= w_lock_next;
            r_phase_sel <= w_phase_sel_next;

            if (r_state == ST_IDLE && bus.start) begin
                r_chan_sel <= 4'd0;
            end else if (r_state == ST_NEXT && !w_chan_last) begin
                r_chan_sel <= r_chan_sel + 4'd1;
            end

            // Timer restarts on every state change so each phase counts from 0.
            if (w_state_next != r_state) begin
                r_timer <= 16'd0;
            end else if (w_counting) begin
                r_timer <= r_timer + 16'd1;
            end

            if (w_eval) begin
                r_hist <= r_bins;
            end
        end
    end

    assign bus.pulse_gate = (r_state == ST_MEASURE);
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.done       = (r_state == ST_DONE);
    assign bus.phase      = r_phase;
    assign bus.chan_sel   = r_chan_sel;
    assign bus.lock       = r_lock;
    assign bus.phase_sel  = r_phase_sel;
    assign bus.hist0      = r_hist[7:0];
    assign bus.hist1      = r_hist[15:8];
    assign bus.hist2      = r_hist[23:16];
    assign bus.hist3      = r_hist[31:24];

endmodule

// File: tb/tb_trig_phase_cal_ctrl.sv
// Bench for trig_phase_cal_ctrl: per-channel evaluation results are queued as
// expectations when a scan is launched and matched against each EVAL outcome.
module tb_trig_phase_cal_ctrl;

    localparam int NA = 2;
    localparam int WA = 16;
    localparam int SA = 4;
    localparam int NB = 1;
    localparam int WB = 1200;
    localparam int SB = 4;
    localparam int SCAN_A = NA * (WA + SA + 3) + 1;
    localparam int SCAN_B = NB * (WB + SB + 3) + 1;

    typedef struct packed {
        logic [3:0]  ch;
        logic [31:0] hist;
        logic        lk;
        logic [1:0]  ps;
    } res_t;

    logic       clk_adc = 1'b0;
    logic       rst     = 1'b1;
    logic [1:0] tb_phase;

    res_t exp_q[$];
    res_t obs_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk_adc = ~clk_adc;

    trig_phase_cal_ctrl_if a_if ();
    trig_phase_cal_ctrl_if b_if ();

    trig_phase_cal_ctrl #(.NCHAN(NA), .WINDOW_LEN(WA), .SETTLE_LEN(SA)) dut_a (
        .clk_adc (clk_adc),
        .rst     (rst),
        .bus     (a_if)
    );

    trig_phase_cal_ctrl #(.NCHAN(NB), .WINDOW_LEN(WB), .SETTLE_LEN(SB)) dut_b (
        .clk_adc (clk_adc),
        .rst     (rst),
        .bus     (b_if)
    );

    // Independent model of the free-running phase counter.
    always @(posedge clk_adc or posedge rst) begin
        if (rst) tb_phase <= 2'd0;
        else     tb_phase <= tb_phase + 2'd1;
    end

    function automatic res_t mk(input int ch, input int h0, input int h1, input int h2,
                                input int h3, input bit lk, input int ps);
        res_t r;
        r.ch   = 4'(ch);
        r.hist = {8'(h3), 8'(h2), 8'(h1), 8'(h0)};
        r.lk   = lk;
        r.ps   = 2'(ps);
        return r;
    endfunction

    // Runs one scan on dut_a. pat selects the ch0 stimulus; start_mode 1 re-pulses
    // start mid-scan, 2 pulses it on the DONE cycle. Records each EVAL outcome.
    task automatic run_scan_a(input int pat, input int start_mode, output int cyc,
                              output int done_at, output int ndone, output bit to);
        bit   prev_gate = 1'b0;
        bit   ev_act    = 1'b0;
        int   ev_cnt    = 0;
        int   ch;
        logic c0;
        res_t r;
        cyc = 0; done_at = 0; ndone = 0; to = 1'b1;
        @(negedge clk_adc);
        a_if.start = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_adc);
            a_if.start = 1'b0;
            if (a_if.busy) cyc++;
            if (a_if.done) begin
                ndone++;
                done_at = cyc;
                if (start_mode == 2) a_if.start = 1'b1;
            end
            if (start_mode == 1 && cyc == SCAN_A / 2 && a_if.busy) a_if.start = 1'b1;
            if (ev_act) begin
                ev_cnt++;
                if (ev_cnt == SA + 1) begin
                    ch     = int'(a_if.chan_sel);
                    r.ch   = a_if.chan_sel;
                    r.hist = {a_if.hist3, a_if.hist2, a_if.hist1, a_if.hist0};
                    r.lk   = a_if.lock[ch];
                    r.ps   = a_if.phase_sel[2*ch +: 2];
                    obs_q.push_back(r);
                    ev_act = 1'b0;
                end
            end
            if (prev_gate && !a_if.pulse_gate) begin
                ev_act = 1'b1;
                ev_cnt = 0;
            end
            prev_gate = a_if.pulse_gate;
            case (pat)
                1:       c0 = a_if.pulse_gate && (tb_phase == 2'd2);
                2:       c0 = a_if.pulse_gate && (tb_phase == 2'd1 || tb_phase == 2'd2);
                3:       c0 = ev_act && (ev_cnt < SA) && (tb_phase == 2'd3);
                default: c0 = 1'b0;
            endcase
            // Bits above the scanned channels carry noise that must be ignored.
            a_if.coax_in = {14'($urandom), 1'b0, c0};
            if (ndone > 0 && !a_if.busy) begin
                to = 1'b0;
                break;
            end
        end
        a_if.coax_in = 16'd0;
        a_if.start   = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (a_if.busy !== 1'b0 || a_if.pulse_gate !== 1'b0 || a_if.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy=%b gate=%b done=%b, required 0 0 0",
                     a_if.busy, a_if.pulse_gate, a_if.done);
        end else $display("reset_ctrl ok");
        n_checks++;
        if (a_if.lock !== 16'd0 || a_if.phase_sel !== 32'd0 || a_if.chan_sel !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_results: lock=%h phase_sel=%h chan_sel=%0d, required zeros",
                     a_if.lock, a_if.phase_sel, a_if.chan_sel);
        end else $display("reset_results ok");
        n_checks++;
        if ({a_if.hist3, a_if.hist2, a_if.hist1, a_if.hist0} !== 32'd0 || a_if.phase !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_hist: hist=%h phase=%0d, required 0 0",
                     {a_if.hist3, a_if.hist2, a_if.hist1, a_if.hist0}, a_if.phase);
        end else $display("reset_hist ok");
    endtask

    task automatic test_phase();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_adc);
            n_checks++;
            if (a_if.phase !== tb_phase || b_if.phase !== tb_phase) begin
                n_fail++;
                $display("FAIL phase_count: a=%0d b=%0d, required %0d", a_if.phase, b_if.phase, tb_phase);
            end else $display("phase_count cycle %0d phase %0d ok", i, tb_phase);
        end
    endtask

    task automatic test_single_lock();
        int cyc, done_at, ndone; bit to; res_t e, o;
        a_if.expected_hits = 8'd4;
        exp_q.push_back(mk(0, 0, 0, 4, 0, 1'b1, 2));
        exp_q.push_back(mk(1, 0, 0, 0, 0, 1'b0, 0));
        run_scan_a(1, 0, cyc, done_at, ndone, to);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL single_lock_eval: nothing observed, required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL single_lock_eval: got %h required %h", o, e); end
                else $display("single_lock ch%0d hist=%h lock=%b ps=%0d ok", o.ch, o.hist, o.lk, o.ps);
            end
        end
        obs_q.delete();
        n_checks++;
        if (to || done_at != SCAN_A || ndone != 1) begin
            n_fail++; $display("FAIL single_lock_timing: timeout=%b done_at=%0d ndone=%0d, required 0 %0d 1",
                               to, done_at, ndone, SCAN_A);
        end else $display("single_lock_timing done at %0d ok", done_at);
        n_checks++;
        if (a_if.lock !== 16'h0001 || a_if.phase_sel[1:0] !== 2'd2) begin
            n_fail++; $display("FAIL single_lock_final: lock=%h ps0=%0d, required 0001 2",
                               a_if.lock, a_if.phase_sel[1:0]);
        end else $display("single_lock_final ok");
    endtask

    task automatic test_ambiguous();
        int cyc, done_at, ndone; bit to; res_t e, o;
        a_if.expected_hits = 8'd4;
        exp_q.push_back(mk(0, 0, 4, 4, 0, 1'b0, 2));
        exp_q.push_back(mk(1, 0, 0, 0, 0, 1'b0, 0));
        run_scan_a(2, 0, cyc, done_at, ndone, to);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL ambiguous_eval: nothing observed, required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL ambiguous_eval: got %h required %h", o, e); end
                else $display("ambiguous ch%0d hist=%h lock=%b ps=%0d ok", o.ch, o.hist, o.lk, o.ps);
            end
        end
        obs_q.delete();
        n_checks++;
        if (to || a_if.lock !== 16'h0000) begin
            n_fail++; $display("FAIL ambiguous_final: timeout=%b lock=%h, required 0 0000", to, a_if.lock);
        end else $display("ambiguous_final ok");
    endtask

    task automatic test_late_hits();
        int cyc, done_at, ndone; bit to; res_t e, o;
        a_if.expected_hits = 8'd1;
        exp_q.push_back(mk(0, 0, 0, 0, 1, 1'b1, 3));
        exp_q.push_back(mk(1, 0, 0, 0, 0, 1'b0, 0));
        run_scan_a(3, 0, cyc, done_at, ndone, to);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL late_hits_eval: nothing observed, required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL late_hits_eval: got %h required %h", o, e); end
                else $display("late_hits ch%0d hist=%h lock=%b ps=%0d ok", o.ch, o.hist, o.lk, o.ps);
            end
        end
        obs_q.delete();
        n_checks++;
        if (to) begin n_fail++; $display("FAIL late_hits_timing: scan timed out, required completion"); end
    endtask

    // Threshold edges: one short of threshold, zero threshold with no hits, exactly at threshold.
    task automatic test_threshold();
        int cyc, done_at, ndone; bit to; res_t e, o;
        int thr[3] = '{5, 0, 4};
        int pat[3] = '{1, 0, 1};
        exp_q.push_back(mk(0, 0, 0, 4, 0, 1'b0, 3));
        exp_q.push_back(mk(1, 0, 0, 0, 0, 1'b0, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1'b0, 3));
        exp_q.push_back(mk(1, 0, 0, 0, 0, 1'b0, 0));
        exp_q.push_back(mk(0, 0, 0, 4, 0, 1'b1, 2));
        exp_q.push_back(mk(1, 0, 0, 0, 0, 1'b0, 0));
        for (int s = 0; s < 3; s++) begin
            a_if.expected_hits = 8'(thr[s]);
            run_scan_a(pat[s], 0, cyc, done_at, ndone, to);
            n_checks++;
            if (to) begin n_fail++; $display("FAIL threshold_timing: scan %0d timed out", s); end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL threshold_eval: nothing observed, required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL threshold_eval: got %h required %h", o, e); end
                else $display("threshold ch%0d hist=%h lock=%b ps=%0d ok", o.ch, o.hist, o.lk, o.ps);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        int cyc, done_at, ndone; bit to;
        a_if.expected_hits = 8'd4;
        run_scan_a(1, 1, cyc, done_at, ndone, to);
        obs_q.delete();
        n_checks++;
        if (to || ndone != 1 || done_at != SCAN_A || cyc != SCAN_A) begin
            n_fail++; $display("FAIL start_midscan: timeout=%b ndone=%0d done_at=%0d busy_cycles=%0d, required 0 1 %0d %0d",
                               to, ndone, done_at, cyc, SCAN_A, SCAN_A);
        end else $display("start_midscan ignored, done at %0d ok", done_at);
        run_scan_a(1, 2, cyc, done_at, ndone, to);
        obs_q.delete();
        @(negedge clk_adc);
        n_checks++;
        if (to || ndone != 1 || a_if.busy !== 1'b0) begin
            n_fail++; $display("FAIL start_on_done: timeout=%b ndone=%0d busy=%b, required 0 1 0",
                               to, ndone, a_if.busy);
        end else $display("start_on_done ignored ok");
    endtask

    task automatic test_saturation();
        int cyc = 0; bit got = 1'b0;
        b_if.expected_hits = 8'd1;
        @(negedge clk_adc);
        b_if.start   = 1'b1;
        b_if.coax_in = 16'hFFFF;
        for (int i = 0; i < SCAN_B + 100 && !got; i++) begin
            @(negedge clk_adc);
            b_if.start = 1'b0;
            if (b_if.busy) cyc++;
            if (b_if.done) got = 1'b1;
        end
        b_if.coax_in = 16'd0;
        n_checks++;
        if (!got || cyc != SCAN_B) begin
            n_fail++; $display("FAIL sat_timing: done_seen=%b busy_cycles=%0d, required 1 %0d", got, cyc, SCAN_B);
        end else $display("sat_timing done at %0d ok", cyc);
        n_checks++;
        if ({b_if.hist3, b_if.hist2, b_if.hist1, b_if.hist0} !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL sat_hist: got %h required ffffffff",
                               {b_if.hist3, b_if.hist2, b_if.hist1, b_if.hist0});
        end else $display("sat_hist all bins 255 ok");
        n_checks++;
        if (b_if.lock !== 16'h0000) begin
            n_fail++; $display("FAIL sat_lock: got %h required 0000", b_if.lock);
        end else $display("sat_lock ok");
    endtask

    task automatic test_reset_mid_scan();
        int cyc, done_at, ndone; bit to; bit found = 1'b0; res_t e, o;
        a_if.expected_hits = 8'd4;
        @(negedge clk_adc);
        a_if.start = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_adc);
            a_if.start   = 1'b0;
            a_if.coax_in = {15'd0, a_if.pulse_gate && (tb_phase == 2'd2)};
            if (a_if.chan_sel == 4'd1 && a_if.pulse_gate) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found || a_if.lock !== 16'h0001) begin
            n_fail++; $display("FAIL midscan_pre: reached_ch1=%b lock=%h, required 1 0001", found, a_if.lock);
        end else $display("midscan_pre ch1 measuring, lock=%h ok", a_if.lock);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (a_if.pulse_gate !== 1'b0 || a_if.busy !== 1'b0 || a_if.lock !== 16'd0 ||
            a_if.phase_sel !== 32'd0 || a_if.chan_sel !== 4'd0 || a_if.phase !== 2'd0) begin
            n_fail++; $display("FAIL midscan_async_reset: gate=%b busy=%b lock=%h ps=%h chan=%0d phase=%0d, required zeros",
                               a_if.pulse_gate, a_if.busy, a_if.lock, a_if.phase_sel, a_if.chan_sel, a_if.phase);
        end else $display("midscan_async_reset ok");
        @(negedge clk_adc);
        a_if.coax_in = 16'd0;
        rst = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 4, 0, 1'b1, 2));
        exp_q.push_back(mk(1, 0, 0, 0, 0, 1'b0, 0));
        run_scan_a(1, 0, cyc, done_at, ndone, to);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL rescan_eval: nothing observed, required %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL rescan_eval: got %h required %h", o, e); end
                else $display("rescan ch%0d hist=%h lock=%b ps=%0d ok", o.ch, o.hist, o.lk, o.ps);
            end
        end
        obs_q.delete();
        n_checks++;
        if (to || ndone != 1 || done_at != SCAN_A) begin
            n_fail++; $display("FAIL rescan_timing: timeout=%b ndone=%0d done_at=%0d, required 0 1 %0d",
                               to, ndone, done_at, SCAN_A);
        end else $display("rescan_timing done at %0d ok", done_at);
    endtask

    initial begin
        a_if.start = 1'b0; a_if.coax_in = 16'd0; a_if.expected_hits = 8'd0;
        b_if.start = 1'b0; b_if.coax_in = 16'd0; b_if.expected_hits = 8'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk_adc);
        test_reset();
        rst = 1'b0;
        test_phase();
        test_single_lock();
        test_ambiguous();
        test_late_hits();
        test_threshold();
        test_back_to_back();
        test_saturation();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trig_phase_cal_ctrl.md
Name: trig_phase_cal_ctrl

Overview:
Sequencer for trigger phase calibration on the coax inputs of the trigger board. It walks channel by channel through all coax_in lines. For each channel it gates the test-pulse source and histograms the channel's hits into 4 clk_adc phase bins. It then decides whether the channel locks to a single bin, and stores the chosen phase per channel. The result configures the downstream trigger sync-in logic; the histograms feed the readout.

Parameters:
NCHAN, 16, number of coax channels scanned (1..16)
WINDOW_LEN, 250, cycles test-pulse gate is held high per channel (1..65535)
SETTLE_LEN, 8, cycles of continued counting after gate drops, to catch late hits (0..255)

Ports:
clk_adc  in  1  sole clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to begin a full scan
coax_in  in  16  trigger inputs, sampled directly (already at clk_adc)
expected_hits  in  8  minimum hit count in the winning bin for lock
pulse_gate  out  1  high while the test-pulse source must fire
phase  out  2  free-running phase-bin counter
chan_sel  out  4  channel currently measured
busy  out  1  high from CLEAR of ch0 through DONE
done  out  1  one-cycle pulse at end of scan
lock  out  16  per-channel lock flag
phase_sel  out  32  per-channel chosen phase, bits [2c+1:2c] for channel c
hist0..hist3  out  8 each  bin counts of the last evaluated channel

Behaviour:
- Reset (async): state=IDLE; phase, chan_sel, bins, lock, phase_sel, hist0..3 = 0; pulse_gate, busy, done = 0.
- phase increments by 1 mod 4 every cycle, in every state after reset.
- States: IDLE, CLEAR, MEASURE, SETTLE, EVAL, NEXT, DONE.
- IDLE: start=1 -> CLEAR, chan_sel=0. Lock and phase_sel hold their previous scan results until that channel is re-evaluated.
- CLEAR (1 cycle): all 4 bins <= 0 -> MEASURE.
- MEASURE (exactly WINDOW_LEN cycles): pulse_gate=1. Each cycle, if coax_in[chan_sel]=1, bin[phase] increments. Last cycle -> SETTLE, or EVAL if SETTLE_LEN=0.
- SETTLE (SETTLE_LEN cycles): pulse_gate=0; counting continues exactly as in MEASURE -> EVAL.
- EVAL (1 cycle): hist0..3 <= bins.
  - Lock when exactly one bin k is nonzero and bin[k] >= expected_hits: lock[c]=1, phase_sel[c]=k.
  - Otherwise: lock[c]=0, phase_sel[c] unchanged.
  - expected_hits=0 with all bins zero: no lock.
- NEXT (1 cycle): chan_sel=NCHAN-1 -> DONE; else chan_sel+1 -> CLEAR.
- DONE (1 cycle): done=1 -> IDLE.
- busy=1 in every state except IDLE.
- Bins are 8-bit and saturate at 255; no wrap.
- start while busy is ignored; start on the same cycle DONE is active is also ignored.
- Timing: per-channel time is WINDOW_LEN+SETTLE_LEN+3 cycles. Full scan takes NCHAN*(WINDOW_LEN+SETTLE_LEN+3)+1 cycles from the first CLEAR to the DONE cycle inclusive.
- Reset mid-scan returns to IDLE immediately, with all outputs at their reset values.
- coax_in bits at index >= NCHAN are never examined.

Test Plan:
1. Single lock (NCHAN=2, WINDOW_LEN=16, SETTLE_LEN=4, expected_hits=4): coax_in[0] high only when phase==2 during MEASURE, ch1 idle -> lock=0x0001, phase_sel[1:0]=2, ch1 hist all 0 and lock[1]=0, done at cycle 2*23+1=47 after first CLEAR.
2. Ambiguous: coax_in[0] high whenever phase is 1 or 2 -> bins {0,4,4,0}, lock[0]=0, phase_sel[1:0] keeps its prior value from test 1 (=2).
3. Late hits: hits on ch0 only at phase 3, during SETTLE cycles only, count 1, expected_hits=1 -> lock[0]=1, phase_sel[1:0]=3.
4. Saturation: WINDOW_LEN=1200, coax_in[0] constantly high -> each bin saturates at 255, lock[0]=0.
5. start re-pulsed at the midpoint of a scan -> ignored, exactly one done pulse, total cycle count unchanged.
6. rst asserted during MEASURE of ch1 -> pulse_gate, busy, lock, phase_sel = 0 asynchronously, state IDLE. A subsequent start performs a clean full scan.
